// File: rtl/frame_tx_11011_pkg.sv
// ============================================================================
// frame_tx_pkg : shared types and constants for the frame_tx_11011 transmitter
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    STUFF  = 3'd3,
    PARITY = 3'd4
  } state_t;

  localparam logic [4:0] SYNC_WORD     = 5'b11011;
  localparam int         SYNC_LEN      = 5;
  localparam logic [3:0] STUFF_TRIGGER = 4'b1101;
  localparam logic       STUFF_BIT     = 1'b0;

  // Sync bits go out MSB first; idx counts transmitted sync bits from 0.
  function automatic logic sync_bit(input logic [2:0] idx);
    return SYNC_WORD[3'(SYNC_LEN - 1) - idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_tx_11011_if.sv
// ============================================================================
// frame_tx_11011_if : word handshake and serial line bundle
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface frame_tx_11011_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              tx_bit;
  logic              tx_en;
  logic              busy;
  logic              frame_done;

  modport master (
    output data_in, valid,
    input  ready, tx_bit, tx_en, busy, frame_done
  );

  modport slave (
    input  data_in, valid,
    output ready, tx_bit, tx_en, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/frame_tx_11011_stuff_tracker.sv
// ============================================================================
// frame_tx_stuff_tracker : history of the last four payload/stuff bits
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module frame_tx_stuff_tracker
  import frame_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic stuff_req
);

  logic [3:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hist <= 4'b0000;
    end else if (shift_en) begin
      hist <= {hist[2:0], bit_in};
    end
  end

  // One more '1' after 1101 would reproduce the sync word.
  assign stuff_req = (hist == STUFF_TRIGGER);

endmodule

`default_nettype wire

// File: rtl/frame_tx_11011.sv
// ============================================================================
// frame_tx_11011 : bit-stuffed serial frame transmitter (sync 11011 + payload)
// Optional even parity bit when FRAME_TX_PARITY_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module frame_tx_11011
  import frame_tx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  frame_tx_11011_if.slave    bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   sr, sr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2:0]          sync_idx, sync_idx_nxt;
  logic                tx_bit_q, tx_bit_nxt;
  logic                tx_en_q, tx_en_nxt;
  logic                frame_done_q, frame_done_nxt;
  logic                ready_q, busy_q;
  logic                hist_clear, hist_shift, hist_bit, stuff_req;
  logic                payload_step;
`ifdef FRAME_TX_PARITY_EN
  logic                par, par_nxt;
`endif

  frame_tx_stuff_tracker u_stuff (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (hist_clear),
    .shift_en  (hist_shift),
    .bit_in    (hist_bit),
    .stuff_req (stuff_req)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      sync_idx     <= '0;
      tx_bit_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      sr           <= sr_nxt;
      cnt          <= cnt_nxt;
      sync_idx     <= sync_idx_nxt;
      tx_bit_q     <= tx_bit_nxt;
      tx_en_q      <= tx_en_nxt;
      frame_done_q <= frame_done_nxt;
      ready_q      <= (state_nxt == IDLE);
      busy_q       <= (state_nxt != IDLE);
`ifdef FRAME_TX_PARITY_EN
      par          <= par_nxt;
`endif
    end
  end

  // state names the bit currently on the line; this block picks the next one.
  always_comb begin
    state_nxt      = state;
    sr_nxt         = sr;
    cnt_nxt        = cnt;
    sync_idx_nxt   = sync_idx;
    tx_bit_nxt     = 1'b0;
    tx_en_nxt      = 1'b0;
    frame_done_nxt = 1'b0;
    hist_clear     = 1'b0;
    hist_shift     = 1'b0;
    hist_bit       = 1'b0;
    payload_step   = 1'b0;
`ifdef FRAME_TX_PARITY_EN
    par_nxt        = par;
`endif

    case (state)
      IDLE: begin
        if (bus.valid) begin
          state_nxt    = SYNC;
          sr_nxt       = bus.data_in;
          cnt_nxt      = CNT_W'(DATA_W);
          sync_idx_nxt = 3'd0;
          hist_clear   = 1'b1;
          tx_bit_nxt   = sync_bit(3'd0);
          tx_en_nxt    = 1'b1;
`ifdef FRAME_TX_PARITY_EN
          par_nxt      = ^bus.data_in;
`endif
        end
      end
      SYNC: begin
        if (sync_idx != 3'(SYNC_LEN - 1)) begin
          sync_idx_nxt = sync_idx + 3'd1;
          tx_bit_nxt   = sync_bit(sync_idx + 3'd1);
          tx_en_nxt    = 1'b1;
        end else begin
          payload_step = 1'b1;
        end
      end
      DATA, STUFF: payload_step = 1'b1;
`ifdef FRAME_TX_PARITY_EN
      PARITY: begin
        state_nxt      = IDLE;
        frame_done_nxt = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (payload_step) begin
      tx_en_nxt = 1'b1;
      if (cnt != '0) begin
        hist_shift = 1'b1;
        if (stuff_req) begin
          state_nxt  = STUFF;
          tx_bit_nxt = STUFF_BIT;
          hist_bit   = STUFF_BIT;
        end else begin
          state_nxt  = DATA;
          tx_bit_nxt = sr[DATA_W-1];
          hist_bit   = sr[DATA_W-1];
          sr_nxt     = {sr[DATA_W-2:0], 1'b0};
          cnt_nxt    = cnt - 1'b1;
        end
      end else begin
`ifdef FRAME_TX_PARITY_EN
        // The parity bit is guarded by the same stuff check as a data bit.
        hist_shift = 1'b1;
        if (stuff_req) begin
          state_nxt  = STUFF;
          tx_bit_nxt = STUFF_BIT;
          hist_bit   = STUFF_BIT;
        end else begin
          state_nxt  = PARITY;
          tx_bit_nxt = par;
          hist_bit   = par;
        end
`else
        tx_en_nxt      = 1'b0;
        state_nxt      = IDLE;
        frame_done_nxt = 1'b1;
`endif
      end
    end
  end

  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire
